// File: rtl/muxkey_lut_pipe.sv
// muxkey_lut_pipe: run-time programmable key->data lookup table with a
// registered valid/ready response stage.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   wr_en/wr_idx/wr_key/  write one entry {vld, key, data}; out-of-range
//   wr_data/wr_vld        indices are ignored
//   clr                   invalidate all entries (beats a same-cycle write)
//   default_out           data returned on a miss
//   req_valid/req_ready/  lookup request handshake and key
//   req_key
//   rsp_valid/rsp_ready   response handshake
//   rsp_data/rsp_hit/     lookup result, lowest matching index wins
//   rsp_idx/rsp_multi
//
// Optional feature: define MUXKEY_LUT_MULTIHIT_EN to build multi-hit
// detection on rsp_multi. Without it rsp_multi is tied to 0.
module muxkey_lut_pipe #(
    parameter int NR_KEY   = 8,
    parameter int KEY_LEN  = 7,
    parameter int DATA_LEN = 32,
    localparam int IDX_LEN = $clog2(NR_KEY)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [IDX_LEN-1:0]  wr_idx,
    input  logic [KEY_LEN-1:0]  wr_key,
    input  logic [DATA_LEN-1:0] wr_data,
    input  logic                wr_vld,
    input  logic                clr,
    input  logic [DATA_LEN-1:0] default_out,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [KEY_LEN-1:0]  req_key,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_LEN-1:0] rsp_data,
    output logic                rsp_hit,
    output logic [IDX_LEN-1:0]  rsp_idx,
    output logic                rsp_multi
);

    localparam logic [IDX_LEN:0] NR_KEY_W = (IDX_LEN+1)'(NR_KEY);

    logic [NR_KEY-1:0]   tbl_vld;
    logic [KEY_LEN-1:0]  tbl_key  [NR_KEY];
    logic [DATA_LEN-1:0] tbl_data [NR_KEY];

    logic                wr_ok;
    logic                accept;
    logic                lk_hit;
    logic [IDX_LEN-1:0]  lk_idx;
    logic [DATA_LEN-1:0] lk_data;
`ifdef MUXKEY_LUT_MULTIHIT_EN
    logic                lk_multi;
    logic                rsp_multi_q;
`endif

    assign wr_ok     = wr_en && ({1'b0, wr_idx} < NR_KEY_W);
    assign req_ready = !rsp_valid || rsp_ready;
    assign accept    = req_valid && req_ready;

    // Table storage. clr only drops valid bits; key/data are left as is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl_vld <= '0;
            for (int i = 0; i < NR_KEY; i++) begin
                tbl_key[i]  <= '0;
                tbl_data[i] <= '0;
            end
        end else if (clr) begin
            tbl_vld <= '0;
        end else if (wr_ok) begin
            tbl_vld[wr_idx]  <= wr_vld;
            tbl_key[wr_idx]  <= wr_key;
            tbl_data[wr_idx] <= wr_data;
        end
    end

    // Scan from the top down so the lowest matching index is the one
    // left standing; data is selected, never OR-ed across entries.
    always_comb begin
        lk_hit  = 1'b0;
        lk_idx  = '0;
        lk_data = default_out;
`ifdef MUXKEY_LUT_MULTIHIT_EN
        lk_multi = 1'b0;
`endif
        for (int i = NR_KEY - 1; i >= 0; i--) begin
            if (tbl_vld[i] && (tbl_key[i] == req_key)) begin
`ifdef MUXKEY_LUT_MULTIHIT_EN
                // A second match seen after any earlier one
                lk_multi = lk_multi || lk_hit;
`endif
                lk_hit  = 1'b1;
                lk_idx  = IDX_LEN'(i);
                lk_data = tbl_data[i];
            end
        end
    end

    // Response register: loads on accept, holds while stalled,
    // drains when the consumer takes it and nothing new arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_hit   <= 1'b0;
            rsp_idx   <= '0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_data  <= lk_data;
            rsp_hit   <= lk_hit;
            rsp_idx   <= lk_idx;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef MUXKEY_LUT_MULTIHIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_multi_q <= 1'b0;
        end else if (accept) begin
            rsp_multi_q <= lk_multi;
        end
    end

    assign rsp_multi = rsp_multi_q;

`ifndef SYNTHESIS
    multi_hit_a : assert property (
        @(posedge clk) disable iff (!rst_n)
        !(rsp_valid && rsp_ready && rsp_multi)
    ) else $error("muxkey_lut_pipe: multiple entries matched");
`endif
`else
    assign rsp_multi = 1'b0;
`endif

endmodule

// File: tb/tb_muxkey_lut_pipe.sv
// tb_muxkey_lut_pipe: scoreboard bench for muxkey_lut_pipe.
// Driver pushes model results on accept; a negedge monitor pops and compares.
module tb_muxkey_lut_pipe;

    localparam int NR = 8;
`ifdef MUXKEY_LUT_MULTIHIT_EN
    localparam bit MULTI = 1'b1;
`else
    localparam bit MULTI = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [2:0]  wr_idx;
    logic [6:0]  wr_key;
    logic [31:0] wr_data;
    logic        wr_vld;
    logic        clr;
    logic [31:0] default_out;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  req_key;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_hit;
    logic [2:0]  rsp_idx;
    logic        rsp_multi;

    muxkey_lut_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
        .wr_data(wr_data), .wr_vld(wr_vld), .clr(clr),
        .default_out(default_out),
        .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_hit(rsp_hit),
        .rsp_idx(rsp_idx), .rsp_multi(rsp_multi)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        h;
        logic [2:0]  i;
        logic        m;
    } exp_t;

    exp_t        q[$];
    bit          mv[NR];
    logic [6:0]  mk[NR];
    logic [31:0] md[NR];
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: scan all entries, count matches, first one wins.
    function automatic exp_t model_lookup(input logic [6:0] k);
        exp_t e;
        int n = 0;
        e.d = default_out;
        e.h = 1'b0;
        e.i = 3'd0;
        for (int i = 0; i < NR; i++) begin
            if (mv[i] && mk[i] == k) begin
                if (n == 0) begin
                    e.h = 1'b1;
                    e.i = 3'(i);
                    e.d = md[i];
                end
                n++;
            end
        end
        e.m = MULTI && (n >= 2);
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            mv[i] = 1'b0;
            mk[i] = '0;
            md[i] = '0;
        end
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic drive(input logic we, input logic [2:0] wi,
                         input logic [6:0] wk, input logic [31:0] wd,
                         input logic wv, input logic cl,
                         input logic rv, input logic [6:0] rk,
                         input logic rr);
        wr_en = we; wr_idx = wi; wr_key = wk; wr_data = wd;
        wr_vld = wv; clr = cl;
        req_valid = rv; req_key = rk; rsp_ready = rr;
        #1;
        if (req_valid && req_ready) q.push_back(model_lookup(rk));
        if (cl) begin
            for (int i = 0; i < NR; i++) mv[i] = 1'b0;
        end else if (we) begin
            mv[wi] = wv; mk[wi] = wk; md[wi] = wd;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] wi, input logic [6:0] wk,
                      input logic [31:0] wd);
        drive(1'b1, wi, wk, wd, 1'b1, 1'b0, 1'b0, 7'h0, 1'b1);
    endtask

    task automatic rd(input logic [6:0] rk);
        drive(1'b0, 3'd0, 7'h0, 32'h0, 1'b0, 1'b0, 1'b1, rk, 1'b1);
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 7'h0, 32'h0, 1'b0, 1'b0, 1'b0, 7'h0, 1'b1);
    endtask

    // Monitor: handshake pops, stall stability, req_ready rule.
    bit          held = 1'b0;
    logic [31:0] hd;
    logic        hh;
    logic [2:0]  hi;
    logic        hm;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("stall_valid", 32'(rsp_valid), 32'd1);
                chk("stall_data", rsp_data, hd);
                chk("stall_hit", 32'(rsp_hit), 32'(hh));
                chk("stall_idx", 32'(rsp_idx), 32'(hi));
                chk("stall_multi", 32'(rsp_multi), 32'(hm));
            end
            chk("req_ready", 32'(req_ready),
                32'(!rsp_valid || rsp_ready));
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp", 32'(q.size()), 32'd1);
                end else begin
                    e = q.pop_front();
                    chk("rsp_data", rsp_data, e.d);
                    chk("rsp_hit", 32'(rsp_hit), 32'(e.h));
                    chk("rsp_idx", 32'(rsp_idx), 32'(e.i));
                    chk("rsp_multi", 32'(rsp_multi), 32'(e.m));
                end
            end
            held = rsp_valid && !rsp_ready;
            hd = rsp_data; hh = rsp_hit; hi = rsp_idx; hm = rsp_multi;
        end
    end

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0; wr_idx = '0; wr_key = '0; wr_data = '0;
        wr_vld = 1'b0; clr = 1'b0;
        default_out = 32'h0BAD_F00D;
        req_valid = 1'b0; req_key = '0; rsp_ready = 1'b1;
        model_reset();
        #12;
        chk("reset_valid", 32'(rsp_valid), 32'd0);
        chk("reset_data", rsp_data, 32'd0);
        chk("reset_hit", 32'(rsp_hit), 32'd0);
        chk("reset_idx", 32'(rsp_idx), 32'd0);
        chk("reset_multi", 32'(rsp_multi), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        #0;

        // T2 basic hit with latency-1 check
        wr(3'd3, 7'h13, 32'hDEAD_BEEF);
        rd(7'h13);
        chk("t2_latency", 32'(rsp_valid), 32'd1);
        idle();

        // T3 priority between idx1 and idx5
        wr(3'd1, 7'h05, 32'h0000_AAAA);
        wr(3'd5, 7'h05, 32'h0000_BBBB);
        rd(7'h05);
        idle();

        // T4 same-cycle write not visible to the lookup
        wr(3'd2, 7'h22, 32'd1);
        drive(1'b1, 3'd2, 7'h22, 32'd2, 1'b1, 1'b0, 1'b1, 7'h22, 1'b1);
        rd(7'h22);
        idle();

        // T5 backpressure: one accept, then 3 stalled cycles, then stream
        drive(1'b0, 3'd0, 7'h0, 32'h0, 1'b0, 1'b0, 1'b1, 7'h13, 1'b0);
        for (int c = 0; c < 3; c++)
            drive(1'b0, 3'd0, 7'h0, 32'h0, 1'b0, 1'b0, 1'b1, 7'h05, 1'b0);
        rd(7'h05);
        rd(7'h22);
        rd(7'h13);
        idle();

        // T6 clr wins over same-cycle write
        drive(1'b1, 3'd0, 7'h44, 32'h1234_5678, 1'b1, 1'b1,
              1'b0, 7'h0, 1'b1);
        rd(7'h44);
        rd(7'h13);
        idle();

        // T1 reset mid-response
        wr(3'd4, 7'h13, 32'h5555_0000);
        drive(1'b0, 3'd0, 7'h0, 32'h0, 1'b0, 1'b0, 1'b1, 7'h13, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_valid_drop", 32'(rsp_valid), 32'd0);
        q.delete();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rd(7'h13);
        rd(7'h00);
        idle();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) default_out = $urandom;
            drive($urandom_range(0, 2) == 0,
                  3'($urandom_range(0, 7)),
                  7'($urandom_range(0, 5)),
                  $urandom,
                  $urandom_range(0, 4) != 0,
                  $urandom_range(0, 40) == 0,
                  $urandom_range(0, 3) != 0,
                  7'($urandom_range(0, 6)),
                  $urandom_range(0, 3) != 0);
        end

        // Drain with a bounded wait
        for (int c = 0; c < 20 && q.size() != 0; c++) idle();
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
